lsq_dmem_req_queue: RTL

Request queue between the load/store queue and the data-cache controller. It buffers LSQ memory requests in order and presents them one at a time on the controller's load/store request lines. It retires each request when memory accepts it (nonzero response), and maps returning memory tags back to the originating LSQ entry so load data can be woken up.

---
 rtl/lsq_dmem_req_queue.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/lsq_dmem_req_queue.sv
// lsq_dmem_req_queue: in-order buffer between the LSQ and the data-cache
// controller. Requests are presented one at a time from the FIFO head and
// retire when memory returns a nonzero accept tag. Accepted loads are
// remembered in a 16-entry tag table so returning data can be steered back
// to the originating LSQ entry.
module lsq_dmem_req_queue #(
  parameter int DEPTH = 4,
  parameter int IDX_W = 3
) (
  input  logic             i_clock,
  input  logic             i_reset,
  input  logic             i_lsq_req_valid,
  input  logic             i_lsq_req_is_store,
  input  logic [63:0]      i_lsq_req_addr,
  input  logic [63:0]      i_lsq_req_data,
  input  logic [IDX_W-1:0] i_lsq_req_idx,
  output logic             o_req_ready,
  output logic             o_q2ctr_rd_en,
  output logic [63:0]      o_q2ctr_rd_addr,
  output logic             o_q2ctr_st_en,
  output logic [63:0]      o_q2ctr_st_addr,
  output logic [63:0]      o_q2ctr_st_data,
  input  logic [3:0]       i_ctr2q_response,
  input  logic [3:0]       i_ctr2q_tag,
  input  logic [63:0]      i_ctr2q_tag_data,
  output logic             o_ld_done_valid,
  output logic [IDX_W-1:0] o_ld_done_idx,
  output logic [63:0]      o_ld_done_data,
  output logic             o_st_done_valid,
  output logic [IDX_W-1:0] o_st_done_idx,
  output logic             o_busy
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  // FIFO storage (payload only; never reset)
  logic             r_q_is_store [DEPTH];
  logic [63:0]      r_q_addr     [DEPTH];
  logic [63:0]      r_q_data     [DEPTH];
  logic [IDX_W-1:0] r_q_idx      [DEPTH];

  // FIFO control
  logic [PTR_W-1:0] r_head;
  logic [PTR_W-1:0] r_tail;
  logic [CNT_W-1:0] r_count;

  // Tag table: valid bits are control, idx fields are payload
  logic [15:0]      r_tag_vld;
  logic [IDX_W-1:0] r_tag_idx [16];

  // Store completion pulse
  logic             r_st_done_vld;
  logic [IDX_W-1:0] r_st_done_idx;

  logic w_nonempty;
  logic w_head_st;
  logic w_push;
  logic w_pop;
  logic w_alloc;
  logic w_st_acc;
  logic w_ret;

  assign w_nonempty  = (r_count != '0);
  assign w_head_st   = r_q_is_store[r_head];
  // Ready looks only at the registered count; a same-cycle pop does not
  // make room for a same-cycle push.
  assign o_req_ready = (r_count != FULL_CNT);
  assign w_push      = i_lsq_req_valid & o_req_ready;
  assign w_pop       = w_nonempty & (i_ctr2q_response != 4'd0);
  assign w_alloc     = w_pop & ~w_head_st;
  assign w_st_acc    = w_pop & w_head_st;
  assign w_ret       = (i_ctr2q_tag != 4'd0) & r_tag_vld[i_ctr2q_tag];

  // Write the incoming request into the tail slot
  always_ff @(posedge i_clock) begin
    if (w_push) begin
      r_q_is_store[r_tail] <= i_lsq_req_is_store;
      r_q_addr[r_tail]     <= i_lsq_req_addr;
      r_q_data[r_tail]     <= i_lsq_req_data;
      r_q_idx[r_tail]      <= i_lsq_req_idx;
    end
  end

  // Advance head/tail pointers and track occupancy
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_tail <= r_tail + PTR_W'(1);
      if (w_pop)  r_head <= r_head + PTR_W'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Tag valid bits: a return clears first, a same-tag allocation then wins
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_tag_vld <= '0;
    end else begin
      if (w_ret)   r_tag_vld[i_ctr2q_tag]      <= 1'b0;
      if (w_alloc) r_tag_vld[i_ctr2q_response] <= 1'b1;
    end
  end

  // Record which LSQ entry owns a newly allocated tag
  always_ff @(posedge i_clock) begin
    if (w_alloc) r_tag_idx[i_ctr2q_response] <= r_q_idx[r_head];
  end

  // One-cycle store completion pulse following acceptance
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_st_done_vld <= 1'b0;
      r_st_done_idx <= '0;
    end else begin
      r_st_done_vld <= w_st_acc;
      r_st_done_idx <= w_st_acc ? r_q_idx[r_head] : '0;
    end
  end

  // Present the head entry on exactly one of the load/store request lines
  always_comb begin
    o_q2ctr_rd_en   = 1'b0;
    o_q2ctr_rd_addr = '0;
    o_q2ctr_st_en   = 1'b0;
    o_q2ctr_st_addr = '0;
    o_q2ctr_st_data = '0;
    if (w_nonempty) begin
      if (w_head_st) begin
        o_q2ctr_st_en   = 1'b1;
        o_q2ctr_st_addr = r_q_addr[r_head];
        o_q2ctr_st_data = r_q_data[r_head];
      end else begin
        o_q2ctr_rd_en   = 1'b1;
        o_q2ctr_rd_addr = r_q_addr[r_head];
      end
    end
  end

  // Steer returning load data to its LSQ entry in the same cycle
  always_comb begin
    o_ld_done_valid = 1'b0;
    o_ld_done_idx   = '0;
    o_ld_done_data  = '0;
    if (w_ret) begin
      o_ld_done_valid = 1'b1;
      o_ld_done_idx   = r_tag_idx[i_ctr2q_tag];
      o_ld_done_data  = i_ctr2q_tag_data;
    end
  end

  assign o_st_done_valid = r_st_done_vld;
  assign o_st_done_idx   = r_st_done_idx;
  assign o_busy          = w_nonempty | (|r_tag_vld);

endmodule
